// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU and its host-side controllers:
// op codes, host sequencer state encoding and default latencies.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    // Default ALU latencies (cycles from last operand to valid result byte)
    localparam int LAT_ADDSUB_DEF = 8;
    localparam int LAT_MUL_DEF    = 75;

    typedef enum logic [3:0] {
        IDLE,
        ARST,
        SEND_A,
        SEND_B,
        WAIT,
        CAP_LO,
        CAP_HI,
        RESP,
        GAP
    } alu_host_state_t;

    // Result latency of the ALU for a given op, as an 8-bit counter load value
    function automatic logic [7:0] lat_for_op(input logic [1:0] op,
                                              input int lat_addsub,
                                              input int lat_mul);
        logic [7:0] lat;
        lat = (op == OP_MUL) ? 8'(lat_mul) : 8'(lat_addsub);
        return lat;
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// 8-bit latency down-counter: load a cycle count, decrement while enabled,
// done flags the last counted cycle (count of 1, or an empty counter).
module alu_lat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [7:0] count;

    // Count register: load has priority, decrement saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count <= 8'd1);

endmodule

// File: rtl/alu_host_seq.sv
// Host-side sequencer for the byte-serial sequential ALU. Takes one command
// (op, A, B), replays the ALU loading protocol on its pins, waits the fixed
// latency, collects the result byte(s) and returns a 16-bit response.
// Every output is a register loaded from the next-state decode, so the pins
// line up with the state the FSM is in.
module alu_host_seq
    import alu_pkg::*;
#(
    parameter int LAT_ADDSUB = LAT_ADDSUB_DEF,
    parameter int LAT_MUL    = LAT_MUL_DEF
) (
    input  logic        CLk,
    input  logic        RST_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  alu_inbus,
    output logic [1:0]  alu_op,
    output logic        alu_begin,
    output logic        alu_rst,
    input  logic [7:0]  alu_outbus
);

    alu_host_state_t state, state_nxt;
    logic [1:0] op_q;
    logic [7:0] a_q, b_q;
    logic       cmd_fire;
    logic       cnt_load, cnt_en, cnt_done;

    assign cmd_fire = (state == IDLE) && cmd_ready && cmd_valid;

    alu_lat_counter u_lat (
        .clk      (CLk),
        .rst_n    (RST_n),
        .load     (cnt_load),
        .load_val (lat_for_op(op_q, LAT_ADDSUB, LAT_MUL)),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    // State register; reset drops any operation in flight
    always_ff @(posedge CLk or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and latency counter control
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            IDLE:    if (cmd_fire) state_nxt = (cmd_op == OP_RSV) ? RESP : ARST;
            ARST:    state_nxt = SEND_A;
            SEND_A:  state_nxt = SEND_B;
            SEND_B: begin
                state_nxt = WAIT;
                cnt_load  = 1'b1;
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (cnt_done) state_nxt = CAP_LO;
            end
            CAP_LO:  state_nxt = (op_q == OP_MUL) ? CAP_HI : RESP;
            CAP_HI:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command operands are plain data captured on acceptance
    always_ff @(posedge CLk) begin
        if (cmd_fire) begin
            op_q <= cmd_op;
            a_q  <= cmd_a;
            b_q  <= cmd_b;
        end
    end

    // Registered host-side and ALU-side outputs, decoded from the next state
    always_ff @(posedge CLk or negedge RST_n) begin
        if (!RST_n) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            alu_inbus <= '0;
            alu_op    <= '0;
            alu_begin <= 1'b0;
            alu_rst   <= 1'b1;
        end else begin
            cmd_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            rsp_valid <= (state_nxt == RESP);
            alu_rst   <= (state_nxt == ARST);

            // Op pins change only when a real ALU operation starts, so a
            // reserved op leaves every ALU pin untouched
            if (cmd_fire && (state_nxt == ARST)) alu_op <= cmd_op;

            unique case (state_nxt)
                SEND_A:  alu_inbus <= a_q;
                SEND_B:  alu_inbus <= b_q;
                default: alu_inbus <= '0;
            endcase

            // Begin is held through the response so the only low phase the
            // ALU sees between operations is the GAP cycle
            unique case (state_nxt)
                ARST, SEND_A, SEND_B, WAIT, CAP_LO, CAP_HI: alu_begin <= 1'b1;
                RESP:    alu_begin <= alu_begin;
                default: alu_begin <= 1'b0;
            endcase

            if (cmd_fire) begin
                rsp_data <= '0;
                rsp_err  <= (cmd_op == OP_RSV);
            end else if (state == CAP_LO) begin
                rsp_data <= {8'h00, alu_outbus};
            end else if (state == CAP_HI) begin
                rsp_data[15:8] <= alu_outbus;
            end
        end
    end

endmodule

// File: tb/tb_alu_host_seq.sv
// Directed bench for alu_host_seq with a behavioural byte-serial ALU model.
module tb_alu_host_seq;
    import alu_pkg::*;

    localparam int LA = 8;
    localparam int LM = 75;

    logic        CLk = 1'b0;
    logic        RST_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_a = 8'd0;
    logic [7:0]  cmd_b = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  alu_inbus;
    logic [1:0]  alu_op;
    logic        alu_begin;
    logic        alu_rst;
    logic [7:0]  alu_outbus;

    int checks = 0;
    int errors = 0;

    alu_host_seq #(.LAT_ADDSUB(LA), .LAT_MUL(LM)) dut (
        .CLk        (CLk),
        .RST_n      (RST_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_inbus  (alu_inbus),
        .alu_op     (alu_op),
        .alu_begin  (alu_begin),
        .alu_rst    (alu_rst),
        .alu_outbus (alu_outbus)
    );

    always #5 CLk = ~CLk;

    // ALU model: RST pulse, then A, then B on inbus while Begin is high;
    // result appears on outbus only in the exact cycle(s) it is valid.
    int         ph = 0;
    int         cnt = 0;
    logic [7:0] ma = 8'd0;
    logic [7:0] mb = 8'd0;
    logic [7:0] msum, mdiff;
    logic [15:0] mres;
    int         mlat;

    always @(posedge CLk) begin
        if (alu_rst) begin
            ph  <= 1;
            cnt <= 0;
        end else if (alu_begin) begin
            if (ph == 1) begin
                ma <= alu_inbus;
                ph <= 2;
            end else if (ph == 2) begin
                mb  <= alu_inbus;
                ph  <= 3;
                cnt <= 0;
            end else if (ph == 3) begin
                cnt <= cnt + 1;
            end
        end else begin
            ph <= 0;
        end
    end

    always_comb begin
        msum  = ma + mb;
        mdiff = ma - mb;
        mres  = 16'd0;
        if (alu_op == OP_MUL) mres = 16'(ma) * 16'(mb);
        else if (alu_op == OP_SUB) mres = {8'h00, mdiff};
        else mres = {8'h00, msum};
        mlat = (alu_op == OP_MUL) ? LM : LA;
        alu_outbus = 8'hEE;
        if (ph == 3 && cnt == mlat) alu_outbus = mres[7:0];
        else if (ph == 3 && cnt == mlat + 1 && alu_op == OP_MUL) alu_outbus = mres[15:8];
    end

    task automatic step();
        @(posedge CLk);
        #1;
    endtask

    // Present a command once cmd_ready is seen; returns in cycle 1
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output bit ok);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            step();
            n++;
        end
        ok = cmd_ready;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, input int maxc, output int cyc);
        cyc = start;
        while (!rsp_valid && cyc < maxc) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({alu_rst, cmd_ready, rsp_valid, busy, alu_begin} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_hold: rst/rdy/vld/busy/begin=%b expected 10000",
                     {alu_rst, cmd_ready, rsp_valid, busy, alu_begin});
        end
        checks++;
        if (rsp_data !== 16'h0000 || alu_inbus !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: rsp_data=%h inbus=%h expected 0", rsp_data, alu_inbus);
        end
        RST_n = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || alu_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b alu_rst=%b expected 1 0", cmd_ready, alu_rst);
        end
    endtask

    task automatic test_add();
        bit ok;
        int cyc;
        rsp_ready = 1'b1;
        issue(OP_ADD, 8'd24, 8'd31, ok);
        checks++;
        if (!ok || alu_rst !== 1'b1) begin
            errors++;
            $display("FAIL add_start: accepted=%0d alu_rst=%b expected 1 1", ok, alu_rst);
        end
        wait_rsp(1, 200, cyc);
        checks++;
        if (rsp_valid !== 1'b1 || cyc != LA + 5) begin
            errors++;
            $display("FAIL add_latency: valid=%b cycle=%0d expected 1 %0d", rsp_valid, cyc, LA + 5);
        end
        checks++;
        if (rsp_data !== 16'h0037 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL add_data: data=%h err=%b expected 0037 0", rsp_data, rsp_err);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || alu_begin !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_gap: vld=%b begin=%b busy=%b rdy=%b expected 0 0 1 0",
                     rsp_valid, alu_begin, busy, cmd_ready);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_idle: rdy=%b busy=%b expected 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_sub();
        bit ok;
        int cyc;
        rsp_ready = 1'b1;
        issue(OP_SUB, 8'd99, 8'd55, ok);
        wait_rsp(1, 200, cyc);
        checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_data !== 16'h002C || cyc != LA + 5) begin
            errors++;
            $display("FAIL sub_basic: data=%h cycle=%0d expected 002C %0d", rsp_data, cyc, LA + 5);
        end
        issue(OP_SUB, 8'd5, 8'd9, ok);
        wait_rsp(1, 200, cyc);
        checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_data !== 16'h00FC || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap: data=%h err=%b expected 00FC 0", rsp_data, rsp_err);
        end
    endtask

    task automatic test_mul();
        bit ok;
        int cyc;
        rsp_ready = 1'b1;
        issue(OP_MUL, 8'd32, 8'd25, ok);
        checks++;
        if (!ok || {alu_rst, alu_begin} !== 2'b11 || alu_op !== OP_MUL || alu_inbus !== 8'h00) begin
            errors++;
            $display("FAIL mul_c1: rst/begin=%b op=%0d inbus=%h expected 11 2 00",
                     {alu_rst, alu_begin}, alu_op, alu_inbus);
        end
        step();
        checks++;
        if ({alu_rst, alu_begin} !== 2'b01 || alu_inbus !== 8'd32) begin
            errors++;
            $display("FAIL mul_c2: rst/begin=%b inbus=%h expected 01 20", {alu_rst, alu_begin}, alu_inbus);
        end
        step();
        checks++;
        if ({alu_rst, alu_begin} !== 2'b01 || alu_inbus !== 8'd25) begin
            errors++;
            $display("FAIL mul_c3: rst/begin=%b inbus=%h expected 01 19", {alu_rst, alu_begin}, alu_inbus);
        end
        step();
        checks++;
        if ({alu_rst, alu_begin} !== 2'b01 || alu_inbus !== 8'h00 || alu_op !== OP_MUL) begin
            errors++;
            $display("FAIL mul_c4: rst/begin=%b inbus=%h op=%0d expected 01 00 2",
                     {alu_rst, alu_begin}, alu_inbus, alu_op);
        end
        wait_rsp(4, 300, cyc);
        checks++;
        if (rsp_valid !== 1'b1 || cyc != LM + 6) begin
            errors++;
            $display("FAIL mul_latency: valid=%b cycle=%0d expected 1 %0d", rsp_valid, cyc, LM + 6);
        end
        checks++;
        if (rsp_data !== 16'h0320 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL mul_data: data=%h err=%b expected 0320 0", rsp_data, rsp_err);
        end
    endtask

    task automatic test_reserved();
        bit ok;
        rsp_ready = 1'b1;
        issue(OP_RSV, 8'hFF, 8'hFF, ok);
        checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin
            errors++;
            $display("FAIL rsv_rsp: vld=%b err=%b data=%h expected 1 1 0000", rsp_valid, rsp_err, rsp_data);
        end
        checks++;
        if ({alu_rst, alu_begin} !== 2'b00 || alu_inbus !== 8'h00 || alu_op !== OP_MUL) begin
            errors++;
            $display("FAIL rsv_pins_c1: rst/begin=%b inbus=%h op=%0d expected 00 00 2",
                     {alu_rst, alu_begin}, alu_inbus, alu_op);
        end
        step();
        checks++;
        if ({alu_rst, alu_begin} !== 2'b00 || alu_inbus !== 8'h00 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsv_pins_c2: rst/begin=%b inbus=%h vld=%b expected 00 00 0",
                     {alu_rst, alu_begin}, alu_inbus, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        rsp_ready = 1'b0;
        issue(OP_ADD, 8'd10, 8'd20, ok);
        wait_rsp(1, 200, cyc);
        checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_data !== 16'h001E) begin
            errors++;
            $display("FAIL bp_first: vld=%b data=%h expected 1 001E", rsp_valid, rsp_data);
        end
        cmd_op = OP_SUB;
        cmd_a = 8'd50;
        cmd_b = 8'd8;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h001E || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b data=%h err=%b rdy=%b expected 1 001E 0 0",
                         i, rsp_valid, rsp_data, rsp_err, cmd_ready);
            end
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_gap: vld=%b rdy=%b expected 0 0", rsp_valid, cmd_ready);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b1 || alu_rst !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: rdy=%b alu_rst=%b expected 1 0", cmd_ready, alu_rst);
        end
        step();
        cmd_valid = 1'b0;
        checks++;
        if (alu_rst !== 1'b1 || cmd_ready !== 1'b0 || alu_op !== OP_SUB) begin
            errors++;
            $display("FAIL bp_accept: alu_rst=%b rdy=%b op=%0d expected 1 0 1", alu_rst, cmd_ready, alu_op);
        end
        wait_rsp(1, 200, cyc);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h002A || cyc != LA + 5) begin
            errors++;
            $display("FAIL bp_second: data=%h cycle=%0d expected 002A %0d", rsp_data, cyc, LA + 5);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        int seen;
        rsp_ready = 1'b1;
        issue(OP_MUL, 8'd7, 8'd9, ok);
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (!ok || busy !== 1'b1 || alu_begin !== 1'b1) begin
            errors++;
            $display("FAIL mid_inflight: busy=%b begin=%b expected 1 1", busy, alu_begin);
        end
        RST_n = 1'b0;
        #1;
        checks++;
        if ({alu_rst, busy, rsp_valid, cmd_ready, alu_begin} !== 5'b10000) begin
            errors++;
            $display("FAIL mid_async: rst/busy/vld/rdy/begin=%b expected 10000",
                     {alu_rst, busy, rsp_valid, cmd_ready, alu_begin});
        end
        for (int i = 0; i < 3; i++) step();
        RST_n = 1'b1;
        seen = 0;
        for (int i = 0; i < LM + 10; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_discard: valid_cycles=%0d busy=%b expected 0 0", seen, busy);
        end
        issue(OP_ADD, 8'd1, 8'd2, ok);
        wait_rsp(1, 200, cyc);
        checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_data !== 16'h0003 || cyc != LA + 5) begin
            errors++;
            $display("FAIL mid_recover: data=%h cycle=%0d expected 0003 %0d", rsp_data, cyc, LA + 5);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
